mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
- Initiator for the 8-entry x 8-bit register-file memory interface (addr/wen/ren/wdata in, data_out back).
- Accepts burst commands over a valid/ready port and sequences single-beat memory accesses.
- Streams write data in and read data out with backpressure.
- Sits between a host/command FSM and the memory block; the memory writes on posedge when wen=1 and returns read data combinationally while ren=1.

Parameters:
- DEPTH, 8, number of memory entries; addresses wrap modulo DEPTH.
- AW, 4, memory address width.
- DW, 8, data width.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst_n  input  1  reset; asynchronous and active-high (rst_n=1 resets), one clock.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
- cmd_op  input  2  00=read, 01=write, 10=fill, 11=reserved.
- cmd_addr  input  AW  start address.
- cmd_len  input  4  beats minus 1 (1..16 beats).
- cmd_fill_data  input  DW  fill value (fill op only).
- wr_valid  input  1  write beat offered.
- wr_ready  output  1  write beat consumed.
- wr_data  input  DW  write beat data.
- rd_valid  output  1  read beat available.
- rd_ready  input  1  read beat consumed.
- rd_data  output  DW  read beat data.
- mem_addr  output  AW  to memory addr.
- mem_wen  output  1  to memory wen.
- mem_ren  output  1  to memory ren.
- mem_wdata  output  DW  to memory wdata.
- mem_rdata  input  DW  from memory data_out.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after last beat completes.
- err  output  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (rst_n=1, async): state=IDLE. All outputs 0: cmd_ready, wr_ready, rd_valid, rd_data, mem_*, busy, done, err. Internal addr and beat counters cleared.
- States: IDLE, WR, RD, DRAIN.
- IDLE: cmd_ready=1.
  - On handshake, latch addr=cmd_addr mod DEPTH, remaining=cmd_len.
  - op 00 -> RD; op 01 -> WR; op 10 -> WR with fill source.
  - op 11 -> stay IDLE, err=1 next cycle.
  - cmd_addr >= DEPTH -> reject, err=1, stay IDLE.
- WR:
  - wr_ready=1 (stream source) and mem_wen = wr_valid; combinational in this state.
  - mem_addr = addr; mem_wdata = wr_data.
  - On each wr_valid&wr_ready, addr <= (addr==DEPTH-1)?0:addr+1 and remaining decrements.
  - Fill source: wr_ready=0, mem_wen=1 every cycle, mem_wdata=latched fill data.
  - Beat with remaining==0 -> IDLE, done=1 next cycle.
- RD:
  - mem_ren = !rd_valid | rd_ready; mem_addr = addr.
  - When mem_ren=1, rd_data <= mem_rdata and rd_valid <= 1 on the next edge; addr advances with the same wrap rule.
  - rd_valid clears on rd_ready when no new beat is issued.
  - Read latency: 1 cycle from mem_ren to rd_valid.
  - After the last beat is issued -> DRAIN.
- DRAIN: mem_ren=0. Wait until rd_valid&rd_ready for the final beat, then IDLE, done=1.
- busy=1 in WR/RD/DRAIN.
- cmd_ready=0 outside IDLE; a command held across DRAIN is accepted in the first IDLE cycle.
- mem_wen and mem_ren are never both 1. mem_addr=0 in IDLE.
- Bursts longer than DEPTH wrap and overwrite/re-read entries; this is legal.
- Reset mid-burst aborts immediately: no done pulse, pending rd_valid dropped, memory keeps any beats already written.

Optional Feature:
- Macro MEM_BURST_MASTER_FILL_EN.
- Defined: op 10 performs the fill burst described above, one beat per cycle with no wr_* handshake.
- Undefined: op 10 is rejected like op 11 (err pulse, no memory access), and the fill datapath and cmd_fill_data register are absent.

Test Plan:
- Write op 01, addr=2, len=2, wr_data 0xA1,0xB2,0xC3 with wr_valid gapped by one cycle -> mem_wen high only on valid cycles, writes to 2,3,4; done one cycle after 0xC3; busy low afterward.
- Read op 00, addr=6, len=3 after memory preloaded to value=index -> rd_data 0x06,0x07,0x00,0x01 (wrap at DEPTH=8); rd_valid 1 cycle after each mem_ren.
- Same read with rd_ready low for 3 cycles on beat 2 -> mem_ren held 0, rd_data 0x07 stable; no beat lost or duplicated; done after final handshake.
- Op 11 or cmd_addr=9 -> err pulse 1 cycle, no mem_wen/mem_ren, cmd_ready stays 1.
- Fill op 10, addr=0, len=7, fill=0x5A with FILL_EN defined -> 8 consecutive mem_wen cycles, addresses 0..7; without the macro -> err pulse, no writes.
- rst_n asserted in the 2nd beat of a len=4 write -> all outputs 0 asynchronously; no done; next command accepted after rst_n deasserts.

Source files
------------

// File: rtl/mem_burst_master_if.sv
// mem_burst_master_if: command port, write/read beat streams and memory-side bus
// for the burst master. The master modport is the burst master's view.
interface mem_burst_master_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [DW-1:0] cmd_fill_data;

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill_data,
    input  wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output mem_addr, mem_wen, mem_ren, mem_wdata, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill_data,
    output wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  mem_addr, mem_wen, mem_ren, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns burst commands into single-beat register-file accesses.
// Define MEM_BURST_MASTER_FILL_EN to enable the fill op (cmd_op=10).
module mem_burst_master #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8
) (
  input logic                clk,
  input logic                rst_n,
  mem_burst_master_if.master bus
);
  localparam int unsigned   LW        = 4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [AW-1:0] addr_inc_c;
  logic          op_ok_c;
  logic          fill_active_c;
  logic          beat_c;
  logic          ren_c;

`ifdef MEM_BURST_MASTER_FILL_EN
  logic          fill_q, fill_d;
  logic [DW-1:0] fill_data_q, fill_data_d;

  assign fill_active_c = fill_q;
  assign op_ok_c       = (bus.cmd_op != 2'b11);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end
`else
  assign fill_active_c = 1'b0;
  assign op_ok_c       = !bus.cmd_op[1];
`endif

  assign addr_inc_c = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Next-state, beat sequencing and the memory-side strobes
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    beat_c        = 1'b0;
    ren_c         = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_wdata = '0;
`ifdef MEM_BURST_MASTER_FILL_EN
    fill_d        = fill_q;
    fill_data_d   = fill_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_ready_q && bus.cmd_valid) begin
          if ((bus.cmd_addr > LAST_ADDR) || !op_ok_c) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr;
            rem_d   = bus.cmd_len;
            state_d = (bus.cmd_op == 2'b00) ? RD : WR;
`ifdef MEM_BURST_MASTER_FILL_EN
            fill_d      = (bus.cmd_op == 2'b10);
            fill_data_d = bus.cmd_fill_data;
`endif
          end
        end
      end

      WR: begin
        bus.mem_addr = addr_q;
`ifdef MEM_BURST_MASTER_FILL_EN
        if (fill_active_c) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = fill_data_q;
          beat_c        = 1'b1;
        end else begin
          bus.wr_ready  = 1'b1;
          bus.mem_wen   = bus.wr_valid;
          bus.mem_wdata = bus.wr_data;
          beat_c        = bus.wr_valid;
        end
`else
        bus.wr_ready  = !fill_active_c;
        bus.mem_wen   = bus.wr_valid;
        bus.mem_wdata = bus.wr_data;
        beat_c        = bus.wr_valid;
`endif
        if (beat_c) begin
          addr_d = addr_inc_c;
          rem_d  = rem_q - LW'(1);
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      RD: begin
        // Issue a new beat only when the output register is free or being drained
        ren_c        = !rd_valid_q || bus.rd_ready;
        bus.mem_ren  = ren_c;
        bus.mem_addr = addr_q;
        if (ren_c) begin
          rd_data_d  = bus.mem_rdata;
          rd_valid_d = 1'b1;
          addr_d     = addr_inc_c;
          rem_d      = rem_q - LW'(1);
          if (rem_q == '0) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (rd_valid_q && bus.rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = IDLE;
          done_d     = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed bursts against a bench-owned register file, checked
// every cycle by a queue-based transaction model plus hand-computed literals.
module tb_mem_burst_master;
  logic clk;
  logic rst_n;

  mem_burst_master_if #(.AW(4), .DW(8)) bus ();

  mem_burst_master #(.DEPTH(8), .AW(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MEM_BURST_MASTER_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int         errors = 0;
  int         checks = 0;

  logic [7:0] mem_arr [8];
  logic [7:0] ref_mem [8];
  logic       preload;
  logic [7:0] wdat    [16];
  logic [7:0] lit     [4];

  wr_t        exp_wr[$];
  logic [3:0] exp_ra[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];
  int         wen_cnt = 0;

  logic       busy_m, rdy_m, done_m, err_m, prev_ren, prev_hold;
  logic       done_n, err_n, busy_n, bad;
  logic [7:0] held;
  wr_t        w;
  logic [7:0] dexp;
  logic [3:0] aexp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file: posedge write, combinational read while ren is high
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= 8'(i);
    end else if (bus.mem_wen) begin
      mem_arr[bus.mem_addr[2:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bus.mem_ren ? mem_arr[bus.mem_addr[2:0]] : 8'h00;

  // Transaction model and per-cycle comparison
  always @(negedge clk) begin
    if (rst_n) begin
      chk("reset_outputs", 32'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data,
                                bus.mem_addr, bus.mem_wen, bus.mem_ren, bus.mem_wdata,
                                bus.busy, bus.done, bus.err}), 32'h0);
      busy_m = 1'b0; rdy_m = 1'b0; done_m = 1'b0; err_m = 1'b0;
      prev_ren = 1'b0; prev_hold = 1'b0;
      exp_wr.delete(); exp_ra.delete(); exp_rd.delete();
    end else begin
      if (preload) for (int i = 0; i < 8; i++) ref_mem[i] = 8'(i);
      chk("busy", 32'(bus.busy), 32'(busy_m));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(rdy_m));
      chk("done", 32'(bus.done), 32'(done_m));
      chk("err", 32'(bus.err), 32'(err_m));
      chk("wen_ren_excl", 32'(bus.mem_wen && bus.mem_ren), 32'h0);
      if (!busy_m)
        chk("idle_mem_bus", 32'({bus.mem_addr, bus.mem_wen, bus.mem_ren}), 32'h0);
      if (prev_ren) chk("rd_latency", 32'(bus.rd_valid), 32'h1);
      if (prev_hold) chk("rd_hold", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, held}));

      done_n = 1'b0; err_n = 1'b0; busy_n = busy_m;
      if (bus.mem_wen) begin
        chk("write_expected", 32'(exp_wr.size() > 0), 32'h1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(w.a));
          chk("wr_data", 32'(bus.mem_wdata), 32'(w.d));
          ref_mem[w.a[2:0]] = w.d;
          wen_cnt++;
          if (exp_wr.size() == 0) begin done_n = 1'b1; busy_n = 1'b0; end
        end
      end
      if (bus.mem_ren) begin
        chk("read_expected", 32'(exp_ra.size() > 0), 32'h1);
        if (exp_ra.size() > 0) begin
          aexp = exp_ra.pop_front();
          chk("rd_addr", 32'(bus.mem_addr), 32'(aexp));
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        chk("beat_expected", 32'(exp_rd.size() > 0), 32'h1);
        if (exp_rd.size() > 0) begin
          dexp = exp_rd.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(dexp));
          got_rd.push_back(bus.rd_data);
          if (exp_rd.size() == 0) begin done_n = 1'b1; busy_n = 1'b0; end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        bad = (bus.cmd_op == 2'b11) || (bus.cmd_addr > 4'd7) || (bus.cmd_op == 2'b10 && !FILL);
        if (bad) err_n = 1'b1;
        else     busy_n = 1'b1;
      end
      busy_m = busy_n; rdy_m = !busy_n; done_m = done_n; err_m = err_n;
      prev_ren = bus.mem_ren;
      prev_hold = bus.rd_valid && !bus.rd_ready;
      held = bus.rd_data;
    end
  end

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] len,
                       input logic [7:0] fd);
    int cyc;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a;
    bus.cmd_len = len; bus.cmd_fill_data = fd;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("cmd_accept_timeout", 32'(bus.cmd_ready), 32'h1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] len, input bit gap);
    int i, cyc;
    bit tog;
    for (int k = 0; k <= int'(len); k++)
      exp_wr.push_back('{a: 4'((int'(a) + k) % 8), d: wdat[k]});
    issue(2'b01, a, len, 8'h00);
    i = 0; cyc = 0; tog = 1'b0;
    while (i <= int'(len) && cyc < 100) begin
      bus.wr_valid = !(gap && tog);
      bus.wr_data  = wdat[i];
      tog = !tog;
      if (bus.wr_valid && bus.wr_ready) i++;
      @(posedge clk); #1; cyc++;
    end
    bus.wr_valid = 1'b0;
    chk("wr_complete", 32'(i), 32'(int'(len) + 1));
    chk("wr_done_pulse", 32'(bus.done), 32'h1);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] len, input int stall_beat);
    int hs, stall, cyc;
    for (int k = 0; k <= int'(len); k++) begin
      exp_ra.push_back(4'((int'(a) + k) % 8));
      exp_rd.push_back(ref_mem[(int'(a) + k) % 8]);
    end
    bus.rd_ready = 1'b1;
    issue(2'b00, a, len, 8'h00);
    hs = 0; stall = 0; cyc = 0;
    while (hs <= int'(len) && cyc < 100) begin
      if (bus.rd_valid && hs == stall_beat && stall < 3) begin
        bus.rd_ready = 1'b0; stall++;
      end else begin
        bus.rd_ready = 1'b1;
      end
      if (bus.rd_valid && bus.rd_ready) hs++;
      @(posedge clk); #1; cyc++;
    end
    chk("rd_complete", 32'(hs), 32'(int'(len) + 1));
    chk("rd_done_pulse", 32'(bus.done), 32'h1);
  endtask

  initial begin
    int g0, c0, cyc;
    rst_n = 1'b1; preload = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 4'h0;
    bus.cmd_len = 4'h0; bus.cmd_fill_data = 8'h00;
    bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b1;
    lit[0] = 8'h06; lit[1] = 8'h07; lit[2] = 8'h00; lit[3] = 8'h01;

    @(posedge clk); #1;
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(bus.cmd_ready), 32'h1);

    // Gapped write of three beats to 2,3,4
    do_preload();
    wdat[0] = 8'hA1; wdat[1] = 8'hB2; wdat[2] = 8'hC3;
    c0 = wen_cnt;
    do_write(4'd2, 4'd2, 1'b1);
    @(posedge clk); #1;
    chk("wr_wen_count", 32'(wen_cnt - c0), 32'd3);
    chk("wr_busy_after", 32'(bus.busy), 32'h0);
    chk("mem2", 32'(mem_arr[2]), 32'hA1);
    chk("mem3", 32'(mem_arr[3]), 32'hB2);
    chk("mem4", 32'(mem_arr[4]), 32'hC3);

    // Wrapping read 6,7,0,1, then the same with a stalled second beat
    do_preload();
    for (int s = 0; s < 2; s++) begin
      g0 = got_rd.size();
      do_read(4'd6, 4'd3, (s == 0) ? -1 : 1);
      for (int k = 0; k < 4; k++)
        chk($sformatf("rd%0d_beat%0d", s, k), 32'(got_rd[g0 + k]), 32'(lit[k]));
      @(posedge clk); #1;
      chk("rd_busy_after", 32'(bus.busy), 32'h0);
    end

    // Rejected commands: reserved op and out-of-range address
    c0 = wen_cnt;
    issue(2'b11, 4'd0, 4'd1, 8'h00);
    chk("err_op11", 32'({bus.err, bus.cmd_ready, bus.busy}), 32'b110);
    @(posedge clk); #1;
    chk("err_op11_pulse", 32'(bus.err), 32'h0);
    issue(2'b00, 4'd9, 4'd1, 8'h00);
    chk("err_addr9", 32'({bus.err, bus.cmd_ready, bus.busy}), 32'b110);
    @(posedge clk); #1;
    chk("err_addr9_pulse", 32'(bus.err), 32'h0);

    // Fill burst over the whole memory
    c0 = wen_cnt;
    if (FILL) begin
      for (int k = 0; k < 8; k++) exp_wr.push_back('{a: 4'(k), d: 8'h5A});
      issue(2'b10, 4'd0, 4'd7, 8'h5A);
      cyc = 0;
      while (!bus.done && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      chk("fill_cycles", 32'(cyc), 32'd8);
      chk("fill_wen_count", 32'(wen_cnt - c0), 32'd8);
      chk("fill_mem7", 32'(mem_arr[7]), 32'h5A);
    end else begin
      issue(2'b10, 4'd0, 4'd7, 8'h5A);
      chk("fill_rejected", 32'({bus.err, bus.busy}), 32'b10);
      repeat (3) @(posedge clk); #1;
      chk("fill_no_writes", 32'(wen_cnt - c0), 32'd0);
    end

    // Reset during the second beat of a five-beat write
    do_preload();
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44; wdat[4] = 8'h55;
    for (int k = 0; k < 5; k++) exp_wr.push_back('{a: 4'(k), d: wdat[k]});
    issue(2'b01, 4'd0, 4'd4, 8'h00);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h11;
    @(posedge clk); #1;
    bus.wr_data = 8'h22;
    #2 rst_n = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data,
                                    bus.mem_addr, bus.mem_wen, bus.mem_ren, bus.mem_wdata,
                                    bus.busy, bus.done, bus.err}), 32'h0);
    bus.wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mem0_kept", 32'(mem_arr[0]), 32'h11);
    chk("rst_mem1_untouched", 32'(mem_arr[1]), 32'h01);
    g0 = got_rd.size();
    do_read(4'd0, 4'd1, -1);
    chk("post_rst_beat0", 32'(got_rd[g0]), 32'h11);
    chk("post_rst_beat1", 32'(got_rd[g0 + 1]), 32'h01);
    repeat (2) @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
